// File: rtl/pipe_stage_elastic_pkg.sv
// rtl/pipe_stage_elastic_pkg.sv - shared state encoding for the elastic pipeline stage
package pipe_stage_elastic_pkg;

    typedef enum logic [1:0] {
        PSE_EMPTY = 2'd0,
        PSE_ONE   = 2'd1,
        PSE_TWO   = 2'd2
    } pse_state_e;

    function automatic logic pse_can_accept(input pse_state_e s);
        return s != PSE_TWO;
    endfunction

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// rtl/pipe_stage_elastic_if.sv - valid/ready payload handshake between pipeline stages
interface pipe_stage_elastic_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_stage_elastic_sat_counter.sv
// rtl/pipe_stage_elastic_sat_counter.sv - saturating event counter, cleared only by reset
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline register with optional skid entry,
// synchronous active-low flush and a saturating backpressure counter
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    pipe_stage_elastic_if.slave  up,
    pipe_stage_elastic_if.master down,
    output logic [CNT_W-1:0]     stall_cnt
);

    logic [WIDTH-1:0] main_q;
    logic             main_v;

    assign down.valid = main_v;
    assign down.data  = main_q;

    generate
        if (SKID != 0) begin : g_skid
            pse_state_e       state_q, state_d;
            logic [WIDTH-1:0] skid_q;
            logic             ready_q;
            logic             load_main, load_skid, pop_skid;

            always_comb begin
                state_d   = state_q;
                load_main = 1'b0;
                load_skid = 1'b0;
                pop_skid  = 1'b0;
                if (!clr) begin
                    state_d = PSE_EMPTY;
                end else begin
                    case (state_q)
                        PSE_EMPTY: begin
                            if (up.valid) begin
                                state_d   = PSE_ONE;
                                load_main = 1'b1;
                            end
                        end
                        PSE_ONE: begin
                            if (up.valid && down.ready) begin
                                load_main = 1'b1;
                            end else if (up.valid) begin
                                state_d   = PSE_TWO;
                                load_skid = 1'b1;
                            end else if (down.ready) begin
                                state_d = PSE_EMPTY;
                            end
                        end
                        PSE_TWO: begin
                            // in_ready is low here, so any in_data is not ours to take
                            if (down.ready) begin
                                state_d  = PSE_ONE;
                                pop_skid = 1'b1;
                            end
                        end
                        default: state_d = PSE_EMPTY;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= PSE_EMPTY;
                    ready_q <= 1'b1;
                end else begin
                    state_q <= state_d;
                    ready_q <= pse_can_accept(state_d);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_q <= '0;
                    skid_q <= '0;
                end else if (!clr) begin
                    main_q <= '0;
                    skid_q <= '0;
                end else begin
                    if (load_main) begin
                        main_q <= up.data;
                    end else if (pop_skid) begin
                        main_q <= skid_q;
                    end
                    if (load_skid) begin
                        skid_q <= up.data;
                    end
                end
            end

            assign main_v   = (state_q != PSE_EMPTY);
            assign up.ready = ready_q;
        end else begin : g_single
            logic accept;

            assign up.ready = !main_v || down.ready;
            assign accept   = up.valid && up.ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_q <= '0;
                    main_v <= 1'b0;
                end else if (!clr) begin
                    main_q <= '0;
                    main_v <= 1'b0;
                end else if (accept) begin
                    main_q <= up.data;
                    main_v <= 1'b1;
                end else if (down.ready) begin
                    main_v <= 1'b0;
                end
            end
        end
    endgenerate

    // Sampled before flush so a flush cycle still counts if it was stalled
    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (main_v && !down.ready),
        .cnt   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - scoreboard bench for pipe_stage_elastic
module tb_pipe_stage_elastic;

    logic clk;
    logic rst_n;
    logic a_clr;
    logic s_clr;
    logic z_clr;

    logic [15:0] a_stall;
    logic [3:0]  s_stall;
    logic [15:0] z_stall;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_a[$];
    logic [7:0]  exp_s[$];
    logic [15:0] exp_z[$];

    pipe_stage_elastic_if #(.WIDTH(32)) a_up ();
    pipe_stage_elastic_if #(.WIDTH(32)) a_dn ();
    pipe_stage_elastic_if #(.WIDTH(8))  s_up ();
    pipe_stage_elastic_if #(.WIDTH(8))  s_dn ();
    pipe_stage_elastic_if #(.WIDTH(16)) z_up ();
    pipe_stage_elastic_if #(.WIDTH(16)) z_dn ();

    pipe_stage_elastic #(.WIDTH(32), .SKID(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(a_clr), .up(a_up), .down(a_dn), .stall_cnt(a_stall)
    );
    pipe_stage_elastic #(.WIDTH(8), .SKID(1), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .clr(s_clr), .up(s_up), .down(s_dn), .stall_cnt(s_stall)
    );
    pipe_stage_elastic #(.WIDTH(16), .SKID(0), .CNT_W(16)) dut_z (
        .clk(clk), .rst_n(rst_n), .clr(z_clr), .up(z_up), .down(z_dn), .stall_cnt(z_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && a_clr && a_dn.valid && a_dn.ready) begin
            if (exp_a.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL a_unexpected: got 0x%0h, expected nothing", a_dn.data);
            end else check("a_out", a_dn.data, exp_a.pop_front());
        end
        if (rst_n && s_clr && s_dn.valid && s_dn.ready) begin
            if (exp_s.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL s_unexpected: got 0x%0h, expected nothing", s_dn.data);
            end else check("s_out", s_dn.data, exp_s.pop_front());
        end
        if (rst_n && z_clr && z_dn.valid && z_dn.ready) begin
            if (exp_z.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL z_unexpected: got 0x%0h, expected nothing", z_dn.data);
            end else check("z_out", z_dn.data, exp_z.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        a_clr = 1'b1; s_clr = 1'b1; z_clr = 1'b1;
        a_up.valid = 1'b0; a_up.data = '0; a_dn.ready = 1'b0;
        s_up.valid = 1'b0; s_up.data = '0; s_dn.ready = 1'b0;
        z_up.valid = 1'b0; z_up.data = '0; z_dn.ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        @(negedge clk);
        check("rst_out_valid", a_dn.valid, 0);
        check("rst_out_data", a_dn.data, 0);
        check("rst_stall_cnt", a_stall, 0);
        check("rst_in_ready", a_up.ready, 1);
        check("rst_z_in_ready", z_up.ready, 1);
        tick();

        // Streaming 1..4 with out_ready high
        for (int c = 0; c < 6; c++) begin
            a_up.valid = (c < 4);
            a_up.data  = 32'(c + 1);
            a_dn.ready = 1'b1;
            @(negedge clk);
            check($sformatf("stream_in_ready_%0d", c), a_up.ready, 1);
            check($sformatf("stream_out_valid_%0d", c), a_dn.valid, (c >= 1 && c <= 4) ? 1 : 0);
            if (c < 4) exp_a.push_back(32'(c + 1));
            tick();
        end

        // Backpressure into the skid entry
        a_up.valid = 1'b1; a_up.data = 32'hA; a_dn.ready = 1'b0;
        @(negedge clk);
        check("bp_in_ready_0", a_up.ready, 1);
        exp_a.push_back(32'hA);
        tick();
        a_up.data = 32'hB;
        @(negedge clk);
        check("bp_in_ready_1", a_up.ready, 1);
        check("bp_data_1", a_dn.data, 32'hA);
        check("bp_stall_1", a_stall, 0);
        exp_a.push_back(32'hB);
        tick();
        a_up.valid = 1'b0;
        @(negedge clk);
        check("bp_in_ready_2", a_up.ready, 0);
        check("bp_data_2", a_dn.data, 32'hA);
        check("bp_stall_2", a_stall, 1);
        tick();
        a_dn.ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_3", a_up.ready, 0);
        check("bp_stall_3", a_stall, 2);
        tick();
        @(negedge clk);
        check("bp_in_ready_4", a_up.ready, 1);
        check("bp_data_4", a_dn.data, 32'hB);
        check("bp_stall_4", a_stall, 2);
        tick();
        @(negedge clk);
        check("bp_out_valid_5", a_dn.valid, 0);
        tick();

        // Flush while holding two entries and presenting 0xC
        a_up.valid = 1'b1; a_up.data = 32'hA; a_dn.ready = 1'b0;
        exp_a.push_back(32'hA);
        tick();
        a_up.data = 32'hB;
        @(negedge clk);
        check("fl_in_ready_1", a_up.ready, 1);
        exp_a.push_back(32'hB);
        tick();
        a_up.data = 32'hC; a_dn.ready = 1'b1; a_clr = 1'b0;
        @(negedge clk);
        check("fl_in_ready_2", a_up.ready, 0);
        check("fl_stall_2", a_stall, 3);
        exp_a.delete();
        tick();
        a_clr = 1'b1; a_up.valid = 1'b0;
        @(negedge clk);
        check("fl_out_valid", a_dn.valid, 0);
        check("fl_out_data", a_dn.data, 0);
        check("fl_in_ready", a_up.ready, 1);
        check("fl_stall", a_stall, 3);
        tick();

        // Flush in ONE with an acceptable input present
        a_up.valid = 1'b1; a_up.data = 32'hD; a_dn.ready = 1'b0;
        exp_a.push_back(32'hD);
        tick();
        a_up.data = 32'hE; a_dn.ready = 1'b1; a_clr = 1'b0;
        @(negedge clk);
        check("fl1_in_ready", a_up.ready, 1);
        exp_a.delete();
        tick();
        a_clr = 1'b1; a_up.valid = 1'b0;
        @(negedge clk);
        check("fl1_out_valid", a_dn.valid, 0);
        check("fl1_out_data", a_dn.data, 0);
        check("fl1_stall", a_stall, 3);
        tick();

        // Saturation with CNT_W=4
        s_up.valid = 1'b1; s_up.data = 8'h5A; s_dn.ready = 1'b0;
        exp_s.push_back(8'h5A);
        tick();
        s_up.valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 5) check("sat_mid", s_stall, 5);
            tick();
        end
        @(negedge clk);
        check("sat_end", s_stall, 15);
        check("sat_hold_data", s_dn.data, 8'h5A);
        tick();
        s_dn.ready = 1'b1;
        tick();
        @(negedge clk);
        check("sat_drained", s_dn.valid, 0);
        check("sat_no_wrap", s_stall, 15);
        tick();

        // SKID=0 pass-through
        z_up.valid = 1'b1; z_up.data = 16'h0011; z_dn.ready = 1'b0;
        @(negedge clk);
        check("z_in_ready_0", z_up.ready, 1);
        exp_z.push_back(16'h0011);
        tick();
        z_up.data = 16'h0022;
        @(negedge clk);
        check("z_in_ready_1", z_up.ready, 0);
        check("z_out_data_1", z_dn.data, 16'h0011);
        tick();
        #1;
        check("z_comb_low", z_up.ready, 0);
        z_dn.ready = 1'b1;
        #1;
        check("z_comb_high", z_up.ready, 1);
        @(negedge clk);
        exp_z.push_back(16'h0022);
        tick();
        for (int c = 3; c < 7; c++) begin
            z_up.valid = (c < 5);
            z_up.data  = 16'(c * 16'h0011);
            @(negedge clk);
            check($sformatf("z_out_valid_%0d", c), z_dn.valid, (c < 6) ? 1 : 0);
            if (c < 5) begin
                check($sformatf("z_in_ready_%0d", c), z_up.ready, 1);
                exp_z.push_back(16'(c * 16'h0011));
            end
            tick();
        end
        check("z_stall", z_stall, 1);

        // Asynchronous reset with a payload held
        a_up.valid = 1'b1; a_up.data = 32'hF; a_dn.ready = 1'b0;
        exp_a.push_back(32'hF);
        tick();
        a_up.valid = 1'b0;
        @(negedge clk);
        check("ar_before", a_dn.data, 32'hF);
        #1;
        rst_n = 1'b0;
        exp_a.delete();
        #1;
        check("ar_out_valid", a_dn.valid, 0);
        check("ar_out_data", a_dn.data, 0);
        check("ar_stall", a_stall, 0);
        check("ar_in_ready", a_up.ready, 1);
        tick();
        rst_n = 1'b1;
        tick();

        check("a_leftover", exp_a.size(), 0);
        check("s_leftover", exp_s.size(), 0);
        check("z_leftover", exp_z.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline register for the IF/ID/EX/DM/WB chain, generalising the fixed per-stage registers. It carries a WIDTH-bit packed payload with a valid/ready handshake instead of a bare enable/stall pair, and supports synchronous flush. An optional skid entry (SKID=1) gives full throughput with a registered in_ready. A saturating counter records cycles in which downstream backpressure holds a valid payload.

## Interface
- WIDTH, 32: payload width in bits (≥1).
- SKID, 1: 1 = two-entry elastic stage with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16: width of the stall counter.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous flush, active-low; inserts a bubble.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept in_data this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  WIDTH  payload to the next stage.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid && !out_ready.

## Operation
- Transfers:
  - Input transfer = in_valid && in_ready at a rising edge.
  - Output transfer = out_valid && out_ready at a rising edge.
- Storage:
  - Main register (main_q, main_v) drives out_data and out_valid.
  - Skid register (skid_q, skid_v) exists only when SKID=1.
- SKID=1 state machine:
  - States: EMPTY (main_v=0), ONE (main_v=1, skid_v=0), TWO (both valid).
  - in_ready = (state != TWO), registered.
  - EMPTY: in_valid → ONE, main_q ← in_data.
  - ONE: in_valid && out_ready → ONE, main_q ← in_data.
  - ONE: in_valid && !out_ready → TWO, skid_q ← in_data.
  - ONE: !in_valid && out_ready → EMPTY.
  - ONE: otherwise hold.
  - TWO: out_ready → ONE, main_q ← skid_q; in_data is ignored because in_ready=0.
  - TWO: !out_ready → hold.
- SKID=0:
  - in_ready = !main_v || out_ready, combinational.
  - On an input transfer, main_q ← in_data and main_v ← 1.
  - On an output transfer without an input transfer, main_v ← 0.
- Flush (clr=0):
  - Next state is EMPTY; main_v, skid_v ← 0; main_q, skid_q ← 0.
  - Flush overrides any simultaneous input or output transfer, and the payload presented in that cycle is dropped.
  - in_ready is still driven per its normal rule during clr; upstream is flushed in the same cycle.
  - stall_cnt is not affected by clr.
- Reset (rst_n=0): asynchronous.
  - Outputs: out_valid=0, out_data=0, stall_cnt=0.
  - in_ready = 1 (SKID=1 state EMPTY; SKID=0 main_v=0).
  - Reset asserted mid-transfer discards all stored payload.
- stall_cnt:
  - Increments by 1 on each edge where out_valid && !out_ready, evaluated before the flush takes effect.
  - Saturates at 2^CNT_W−1 and never wraps.
  - Cleared only by rst_n.
- out_data while out_valid=0 is 0 after reset or flush; otherwise it holds the last value and downstream must not use it.

## Timing
- Latency: in_data accepted at edge N appears on out_data and out_valid after edge N.
- Throughput: one transfer per cycle in steady state for both SKID settings.
- SKID=1:
  - in_ready deasserts the cycle after the edge that entered TWO.
  - It reasserts after the edge at which out_ready drained TWO → ONE.
  - Ordering is FIFO; the skid payload always leaves after the main payload.
- SKID=0: in_ready has a combinational path from out_ready.
- Simultaneous input and output transfer in ONE: state is unchanged and the payload is replaced, with no bubble.

## Structure
- Shared constants go in Core.vh: state encodings PSE_EMPTY=2'd0, PSE_ONE=2'd1, PSE_TWO=2'd2.
- Payload field widths stay with the caller, which packs per-stage fields (pc, ctrl, data) into in_data.
- One natural sub-module: sat_counter (parameter W; ports clk, rst_n, inc, cnt) implements stall_cnt.
- SKID generate branches live inside pipe_stage_elastic.

## Test plan
- Reset: rst_n=0 then 1, WIDTH=32 → out_valid=0, out_data=0, stall_cnt=0, in_ready=1.
- Streaming, SKID=1: in_valid=1 with data 1,2,3,4 over consecutive cycles, out_ready=1 → out_data 1,2,3,4 one cycle later, no bubbles, in_ready constantly 1.
- Backpressure, SKID=1:
  - Send 0xA then 0xB, with out_ready=0 from the cycle 0xA appears.
  - Expect: in_ready=0 the cycle after 0xB is accepted; out_data holds 0xA; stall_cnt increments per cycle.
  - Raise out_ready: expect 0xA then 0xB, and in_ready=1 again.
- Flush in TWO: clr=0 for one cycle while holding 0xA/0xB and presenting 0xC → next cycle out_valid=0, out_data=0, 0xC dropped, in_ready=1, stall_cnt unchanged.
- Saturation: CNT_W=4 with out_ready held 0 for 20 cycles while valid → stall_cnt stops at 15.
- SKID=0 pass-through: main full, out_ready=1 and in_valid=1 in the same cycle → in_ready=1 combinationally, payload replaced at the edge, and throughput stays at one transfer per cycle.
